// File: rtl/pifo_dequeue_ctrl_pkg.sv
// Shared scheduler definitions for the PIFO calendar blocks: default widths,
// dequeue FSM encoding and a small sizing helper.
package pifo_dequeue_ctrl_pkg;

  localparam int SCHED_BUFFER_ADDR_WIDTH = 12;
  localparam int SCHED_CREDIT_WIDTH      = 16;

  typedef enum logic [1:0] {
    SCHED_IDLE   = 2'd0,
    SCHED_POP    = 2'd1,
    SCHED_SETTLE = 2'd2
  } sched_deq_state_e;

  // Occupancy counters need one extra bit so "full" is distinguishable from "empty".
  function automatic int sched_fifo_cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sched_addr_fifo.sv
// First-word-fall-through address FIFO used between the PIFO dequeue logic and
// the packet-buffer reader. Writes and reads may coincide even when full.
module sched_addr_fifo
  import pifo_dequeue_ctrl_pkg::*;
#(
  parameter int WIDTH = SCHED_BUFFER_ADDR_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   wr_en,
  input  logic [WIDTH-1:0]                       wr_data,
  input  logic                                   rd_en,
  output logic [WIDTH-1:0]                       rd_data,
  output logic                                   rd_valid,
  output logic [sched_fifo_cnt_width(DEPTH)-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             empty;
  logic             full;
  logic             wr_fire;
  logic             rd_fire;

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign count = wr_ptr_reg - rd_ptr_reg;

  // A write into a full FIFO is only legal when the head leaves on the same edge.
  assign rd_fire = rd_en & ~empty;
  assign wr_fire = wr_en & (~full | rd_fire);

  assign rd_valid = ~empty;
  assign rd_data  = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem[wr_ptr_reg[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (wr_fire) begin
        wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      end
      if (rd_fire) begin
        rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/pifo_dequeue_ctrl.sv
// Credit-shaped dequeue controller: pops the PIFO head into an output address
// FIFO at most once every three cycles, gated by a token-bucket shaper.
module pifo_dequeue_ctrl
  import pifo_dequeue_ctrl_pkg::*;
#(
  parameter int BUFFER_ADDR_WIDTH = SCHED_BUFFER_ADDR_WIDTH,
  parameter int OUT_FIFO_DEPTH    = 4,
  parameter int CREDIT_WIDTH      = SCHED_CREDIT_WIDTH,
  parameter int CREDIT_PER_POP    = 256
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [BUFFER_ADDR_WIDTH-1:0] s_pifo_buffer_addr,
  input  logic                         s_pifo_buffer_addr_valid,
  output logic                         m_pifo_pop_en,
  output logic [BUFFER_ADDR_WIDTH-1:0] m_axis_tdata,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  input  logic                         cfg_enable,
  input  logic [CREDIT_WIDTH-1:0]      cfg_rate,
  input  logic [CREDIT_WIDTH-1:0]      cfg_burst,
  output logic [31:0]                  stat_pop_count
);

  localparam int CNT_W = sched_fifo_cnt_width(OUT_FIFO_DEPTH);
  localparam logic [CREDIT_WIDTH:0] POP_COST = (CREDIT_WIDTH+1)'(CREDIT_PER_POP);

  sched_deq_state_e             state_reg;
  sched_deq_state_e             state_next;
  logic [CREDIT_WIDTH-1:0]      credit_reg;
  logic [CREDIT_WIDTH-1:0]      credit_next;
  logic [31:0]                  pop_count_reg;
  logic [CREDIT_WIDTH:0]        refill;
  logic [CREDIT_WIDTH:0]        refill_capped;
  logic [CREDIT_WIDTH:0]        drained;
  logic [CNT_W-1:0]             fifo_count;
  logic [BUFFER_ADDR_WIDTH-1:0] fifo_data;
  logic                         fifo_valid;
  logic                         fifo_rd;
  logic                         pop;
  logic                         eligible;

  // The pop is qualified by the live head-valid so a head that vanished in the
  // POP cycle cancels the pop, the FIFO write and the credit charge together.
  assign pop = (state_reg == SCHED_POP) & s_pifo_buffer_addr_valid & ~rst;

  always_comb begin
    refill        = {1'b0, credit_reg} + {1'b0, cfg_rate};
    refill_capped = (refill > {1'b0, cfg_burst}) ? {1'b0, cfg_burst} : refill;
    drained       = refill;
    if (pop) begin
      drained = (refill >= POP_COST) ? (refill - POP_COST) : '0;
    end
    credit_next = (drained > {1'b0, cfg_burst}) ? cfg_burst : drained[CREDIT_WIDTH-1:0];
  end

  // Eligibility looks at the credit that will be held in the POP cycle, so the
  // refill landing this cycle already counts toward the decision.
  assign eligible = cfg_enable & s_pifo_buffer_addr_valid &
                    (refill_capped >= POP_COST) &
                    (fifo_count <= CNT_W'(OUT_FIFO_DEPTH - 1));

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      SCHED_IDLE:   if (eligible) state_next = SCHED_POP;
      SCHED_POP:    state_next = SCHED_SETTLE;
      SCHED_SETTLE: state_next = SCHED_IDLE;
      default:      state_next = SCHED_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= SCHED_IDLE;
      credit_reg    <= '0;
      pop_count_reg <= '0;
    end else begin
      state_reg  <= state_next;
      credit_reg <= credit_next;
      if (pop) begin
        pop_count_reg <= pop_count_reg + 32'd1;
      end
    end
  end

  sched_addr_fifo #(
    .WIDTH (BUFFER_ADDR_WIDTH),
    .DEPTH (OUT_FIFO_DEPTH)
  ) u_out_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (pop),
    .wr_data  (s_pifo_buffer_addr),
    .rd_en    (fifo_rd),
    .rd_data  (fifo_data),
    .rd_valid (fifo_valid),
    .count    (fifo_count)
  );

  // Outputs read as idle for the whole reset cycle, not just after the edge.
  assign m_pifo_pop_en  = pop;
  assign m_axis_tvalid  = fifo_valid & ~rst;
  assign m_axis_tdata   = rst ? '0 : fifo_data;
  assign fifo_rd        = m_axis_tvalid & m_axis_tready;
  assign stat_pop_count = rst ? 32'd0 : pop_count_reg;

endmodule

// File: tb/tb_pifo_dequeue_ctrl.sv
// Bench for pifo_dequeue_ctrl: a reactive PIFO source, a timestamp/queue based
// reference model checked every cycle, directed scenarios and a random soak.
module tb_pifo_dequeue_ctrl;

  localparam int AW    = 12;
  localparam int DEPTH = 4;
  localparam int CW    = 16;
  localparam int CPP   = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] s_pifo_buffer_addr = '0;
  logic          s_pifo_buffer_addr_valid = 1'b0;
  logic          m_pifo_pop_en;
  logic [AW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic          cfg_enable = 1'b0;
  logic [CW-1:0] cfg_rate = '0;
  logic [CW-1:0] cfg_burst = '0;
  logic [31:0]   stat_pop_count;

  always #5 clk = ~clk;

  pifo_dequeue_ctrl #(
    .BUFFER_ADDR_WIDTH (AW),
    .OUT_FIFO_DEPTH    (DEPTH),
    .CREDIT_WIDTH      (CW),
    .CREDIT_PER_POP    (CPP)
  ) dut (
    .clk                      (clk),
    .rst                      (rst),
    .s_pifo_buffer_addr       (s_pifo_buffer_addr),
    .s_pifo_buffer_addr_valid (s_pifo_buffer_addr_valid),
    .m_pifo_pop_en            (m_pifo_pop_en),
    .m_axis_tdata             (m_axis_tdata),
    .m_axis_tvalid            (m_axis_tvalid),
    .m_axis_tready            (m_axis_tready),
    .cfg_enable               (cfg_enable),
    .cfg_rate                 (cfg_rate),
    .cfg_burst                (cfg_burst),
    .stat_pop_count           (stat_pop_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  // PIFO source and observation logs
  logic [AW-1:0] pifo[$];
  int            pop_log[$];
  logic [AW-1:0] out_log[$];
  int            out_cyc[$];
  int            cyc = 0;
  bit            saw_pop = 1'b0;
  int            drop_cyc = -1;
  bit            rand_drop = 1'b0;

  // Reference model: credit as a plain integer, FIFO as a queue, and pop timing
  // as "attempt happens the cycle after a decision; next decision 3 cycles on".
  longint        m_credit = 0;
  logic [AW-1:0] m_q[$];
  int unsigned   m_pops = 0;
  int            m_next_free = 0;
  int            m_attempt_at = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_cycle();
    bit     exp_pop;
    bit     exp_tv;
    longint avail;
    longint c;
    if (rst) begin
      chk("rst_pop_en", 32'(m_pifo_pop_en), 32'd0);
      chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
      chk("rst_tdata", 32'(m_axis_tdata), 32'd0);
      chk("rst_stat", stat_pop_count, 32'd0);
      m_credit     = 0;
      m_q.delete();
      m_pops       = 0;
      m_next_free  = 0;
      m_attempt_at = -1;
      saw_pop      = 1'b0;
      cyc          = 0;
    end else begin
      exp_pop = (cyc == m_attempt_at) && s_pifo_buffer_addr_valid;
      exp_tv  = (m_q.size() > 0);
      chk("pop_en", 32'(m_pifo_pop_en), 32'(exp_pop));
      chk("tvalid", 32'(m_axis_tvalid), 32'(exp_tv));
      if (exp_tv) chk("tdata", 32'(m_axis_tdata), 32'(m_q[0]));
      chk("stat_pop_count", stat_pop_count, 32'(m_pops));

      if (m_pifo_pop_en) pop_log.push_back(cyc);
      if (m_axis_tvalid && m_axis_tready) begin
        out_log.push_back(m_axis_tdata);
        out_cyc.push_back(cyc);
      end
      saw_pop = m_pifo_pop_en;

      avail = m_credit + longint'(cfg_rate);
      if (avail > longint'(cfg_burst)) avail = longint'(cfg_burst);
      if (cyc >= m_next_free && cfg_enable && s_pifo_buffer_addr_valid &&
          avail >= CPP && m_q.size() <= DEPTH - 1) begin
        m_attempt_at = cyc + 1;
        m_next_free  = cyc + 3;
      end
      c = m_credit + longint'(cfg_rate) - (exp_pop ? CPP : 0);
      if (c < 0) c = 0;
      if (c > longint'(cfg_burst)) c = longint'(cfg_burst);
      m_credit = c;
      if (exp_tv && m_axis_tready) void'(m_q.pop_front());
      if (exp_pop) begin
        m_q.push_back(s_pifo_buffer_addr);
        m_pops++;
      end
      cyc++;
    end
  endtask

  task automatic drive_src();
    bit drop;
    drop = (cyc == drop_cyc) || (rand_drop && $urandom_range(0, 7) == 0);
    s_pifo_buffer_addr_valid = (pifo.size() > 0) && !drop;
    s_pifo_buffer_addr = (pifo.size() > 0) ? pifo[0] : AW'($urandom);
  endtask

  // One clock: compare at the falling edge, then react to the rising edge.
  task automatic step();
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    #1;
    if (saw_pop && pifo.size() > 0) void'(pifo.pop_front());
    saw_pop = 1'b0;
    drive_src();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic start(input int rate, input int burst, input bit tr);
    rst           = 1'b1;
    cfg_enable    = 1'b1;
    cfg_rate      = CW'(rate);
    cfg_burst     = CW'(burst);
    m_axis_tready = tr;
    run(2);
    pop_log.delete();
    out_log.delete();
    out_cyc.delete();
    rst = 1'b0;
  endtask

  initial begin
    // Basic single pop
    pifo.push_back(12'h0A5);
    start(256, 1024, 1'b1);
    run(10);
    chk("basic_pops", 32'(pop_log.size()), 32'd1);
    chk("basic_pop_cycle", 32'(pop_log.size() > 0 ? pop_log[0] : -1), 32'd1);
    chk("basic_tdata", 32'(out_log.size() > 0 ? out_log[0] : '1), 32'h0A5);
    chk("basic_tvalid_cycle", 32'(out_cyc.size() > 0 ? out_cyc[0] : -1), 32'd2);
    chk("basic_stat", stat_pop_count, 32'd1);

    // Throughput: one pop every 3 cycles, in order
    pifo.delete();
    for (int i = 1; i <= 8; i++) pifo.push_back(AW'(i));
    start(4096, 4096, 1'b1);
    run(30);
    for (int i = 0; i < 8; i++) begin
      chk("thru_pop_cycle", 32'(i < pop_log.size() ? pop_log[i] : -1), 32'(1 + 3 * i));
      chk("thru_order", 32'(i < out_log.size() ? out_log[i] : '1), 32'(i + 1));
    end

    // Backpressure: fill exactly DEPTH, hold head, then drain
    pifo.delete();
    for (int i = 1; i <= 8; i++) pifo.push_back(AW'(i));
    start(4096, 4096, 1'b0);
    run(30);
    chk("bp_pops", 32'(pop_log.size()), 32'(DEPTH));
    chk("bp_tvalid_held", 32'(m_axis_tvalid), 32'd1);
    chk("bp_tdata_held", 32'(m_axis_tdata), 32'd1);
    m_axis_tready = 1'b1;
    run(40);
    chk("bp_drained", 32'(out_log.size()), 32'd8);
    for (int i = 0; i < 8; i++)
      chk("bp_order", 32'(i < out_log.size() ? out_log[i] : '1), 32'(i + 1));

    // Shaping: rate 64, burst 256 -> pops at 4, 8, 12, 16
    pifo.delete();
    for (int i = 0; i < 20; i++) pifo.push_back(AW'(100 + i));
    start(64, 256, 1'b1);
    run(18);
    for (int i = 0; i < 4; i++)
      chk("shape_pop_cycle", 32'(i < pop_log.size() ? pop_log[i] : -1), 32'(4 + 4 * i));

    // Head valid drops in the POP cycle: cancelled, retried at cycle 4
    pifo.delete();
    pifo.push_back(12'h011);
    pifo.push_back(12'h022);
    drop_cyc = 1;
    start(4096, 4096, 1'b1);
    run(8);
    drop_cyc = -1;
    chk("drop_first_pop", 32'(pop_log.size() > 0 ? pop_log[0] : -1), 32'd4);
    chk("drop_first_word", 32'(out_log.size() > 0 ? out_log[0] : '1), 32'h011);

    // Reset during SETTLE with two words buffered
    pifo.delete();
    for (int i = 1; i <= 8; i++) pifo.push_back(AW'(i));
    start(4096, 4096, 1'b0);
    run(5);
    chk("settle_buffered", 32'(m_axis_tvalid), 32'd1);
    rst           = 1'b1;
    cfg_rate      = CW'(64);
    cfg_burst     = CW'(256);
    m_axis_tready = 1'b1;
    #1;
    chk("settle_rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    step();
    pop_log.delete();
    out_log.delete();
    out_cyc.delete();
    rst = 1'b0;
    #1;
    chk("post_rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    run(12);
    chk("post_rst_first_pop", 32'(pop_log.size() > 0 ? pop_log[0] : -1), 32'd4);
    chk("post_rst_first_word", 32'(out_log.size() > 0 ? out_log[0] : '1), 32'd3);

    // Random soak against the model
    pifo.delete();
    for (int i = 0; i < 4000; i++) pifo.push_back(AW'($urandom));
    start(128, 512, 1'b1);
    rand_drop = 1'b1;
    for (int t = 0; t < 3000; t++) begin
      if (t % 97 == 0) begin
        cfg_rate   = CW'($urandom_range(0, 320));
        cfg_burst  = CW'($urandom_range(0, 1100));
        cfg_enable = ($urandom_range(0, 5) != 0);
      end
      m_axis_tready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 499) == 0);
      step();
    end
    rst       = 1'b0;
    rand_drop = 1'b0;
    run(5);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
